// File: rtl/hazard_controller.sv
// Dispatch-side pipeline sequencing: register scoreboard, load/store occupancy,
// single-branch-in-flight FSM, per-stage stalls and front-end kill pulses.
module hazard_controller #(
   parameter int LS_LATENCY   = 2,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        fetch_ready,
   input  logic        dp_valid,
   input  logic [4:0]  dp_rs1,
   input  logic [4:0]  dp_rs2,
   input  logic        dp_use_rs1,
   input  logic        dp_use_rs2,
   input  logic [4:0]  dp_rd,
   input  logic        dp_writes_rd,
   input  logic [1:0]  dp_class,
   input  logic        cp_we,
   input  logic [4:0]  cp_rd,
   input  logic        br_resolve,
   input  logic        br_mispredict,
   output logic        dp_issue,
   output logic [4:0]  stalls,
   output logic [4:0]  kills,
   output logic [31:0] scoreboard,
   output logic [1:0]  dbg_state
);

   localparam int LSW = (LS_LATENCY < 2) ? 1 : $clog2(LS_LATENCY + 1);
   localparam int FW  = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      BR_WAIT = 2'd1,
      FLUSH   = 2'd2
   } state_t;

   state_t         state;
   logic [LSW-1:0] ls_cnt;
   logic [FW-1:0]  flush_cnt;
   logic [31:0]    sb_next;
   logic           raw, waw, ls_busy, ctrl_block, stall_dp;

   assign dbg_state = state;

   // A register being completed this cycle still reads as busy: the clear lands at the edge.
   assign raw        = (dp_use_rs1 & scoreboard[dp_rs1]) | (dp_use_rs2 & scoreboard[dp_rs2]);
   assign waw        = dp_writes_rd & (dp_rd != 5'd0) & scoreboard[dp_rd];
   assign ls_busy    = (ls_cnt != '0) & (dp_class == 2'd1);
   assign ctrl_block = (state != RUN);
   assign dp_issue   = dp_valid & ~raw & ~waw & ~ls_busy & ~ctrl_block;
   assign stall_dp   = dp_valid & ~dp_issue;

   always_comb begin
      stalls = 5'b00000;
      if (state != FLUSH)
         stalls = {stall_dp | ~fetch_ready, stall_dp, stall_dp, 1'b0, 1'b0};
   end

   // Clear first so that a same-cycle set on the same bit wins.
   always_comb begin
      sb_next = scoreboard;
      if (cp_we && cp_rd != 5'd0)
         sb_next[cp_rd] = 1'b0;
      if (dp_issue && dp_writes_rd && dp_rd != 5'd0)
         sb_next[dp_rd] = 1'b1;
      sb_next[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         scoreboard <= '0;
         ls_cnt     <= '0;
      end else begin
         scoreboard <= sb_next;
         if (dp_issue && dp_class == 2'd1)
            ls_cnt <= LSW'(LS_LATENCY);
         else if (ls_cnt != '0)
            ls_cnt <= ls_cnt - LSW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= RUN;
         flush_cnt <= '0;
         kills     <= 5'b00000;
      end else begin
         kills <= 5'b00000;
         case (state)
            RUN: begin
               if (dp_issue && dp_class == 2'd2)
                  state <= BR_WAIT;
            end
            BR_WAIT: begin
               if (br_resolve && br_mispredict) begin
                  state     <= FLUSH;
                  flush_cnt <= FW'(FLUSH_CYCLES);
                  kills     <= 5'b11100;
               end else if (br_resolve) begin
                  state <= RUN;
               end
            end
            FLUSH: begin
               flush_cnt <= flush_cnt - FW'(1);
               if (flush_cnt == FW'(1))
                  state <= RUN;
               else
                  kills <= 5'b11100;
            end
            default: state <= RUN;
         endcase
      end
   end

endmodule

// File: doc/hazard_controller.md
# hazard_controller

Pipeline sequencing controller for the in-order core: replaces the fixed stall generator between Fetch, Decode, Dispatch, Execute and Complete. It keeps a 32-entry register scoreboard, a load/store occupancy counter and a single-branch-in-flight state machine. From these it decides each cycle whether the instruction at Dispatch may issue, drives the five per-stage stall lines, and drives front-end kill pulses after a branch mispredict.

## Interface
Parameters:
- LS_LATENCY, 2: cycles the load/store unit stays occupied after an issue (≥1).
- FLUSH_CYCLES, 2: cycles the front-end kills stay asserted after a mispredict (≥1).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- fetch_ready  in  1  Fetch has a valid instruction.
- dp_valid  in  1  Dispatch holds a decoded instruction.
- dp_rs1, dp_rs2  in  5 each  source register numbers.
- dp_use_rs1, dp_use_rs2  in  1 each  source is actually read.
- dp_rd  in  5  destination register.
- dp_writes_rd  in  1  instruction writes dp_rd.
- dp_class  in  2  0 integer, 1 load/store, 2 branch, 3 reserved (treated as integer).
- cp_we, cp_rd  in  1, 5  Complete writes cp_rd this cycle.
- br_resolve  in  1  Execute resolves the in-flight branch this cycle.
- br_mispredict  in  1  qualifies br_resolve.
- dp_issue  out  1  instruction at Dispatch issues this cycle.
- stalls  out  5  {stall_fc, stall_dc, stall_dp, stall_ex, stall_cp}.
- kills  out  5  {kill_fc, kill_dc, kill_dp, kill_ex, kill_cp}.
- scoreboard  out  32  busy bit per register (debug/verification).

## Operation
- Scoreboard: bit i set ⇒ register i has an issued, uncompleted writer. Bit 0 is never set.
- Hazard terms, all combinational:
  - raw: a used source has its scoreboard bit set. A register cleared by cp_we in the same cycle still counts as busy.
  - waw: dp_writes_rd and scoreboard[dp_rd] set, with dp_rd≠0.
  - ls_busy: ls_cnt≠0 and dp_class==1.
  - ctrl_block: state≠RUN.
- dp_issue = dp_valid & ~raw & ~waw & ~ls_busy & ~ctrl_block.
- On issue:
  - If dp_writes_rd and rd≠0, set scoreboard[rd] at the edge.
  - If dp_class==1, load ls_cnt with LS_LATENCY.
  - If dp_class==2, go to BR_WAIT.
- Scoreboard clear: cp_we with cp_rd≠0 clears scoreboard[cp_rd] at the edge. If a set and a clear hit the same bit in one cycle, the set wins (cannot occur legally because waw blocks it).
- ls_cnt: 0..LS_LATENCY. Decrements by 1 each cycle while nonzero and not being reloaded.
- State machine (2-bit):
  - RUN: normal operation. A branch issue moves to BR_WAIT.
  - BR_WAIT: dispatch blocked.
    - br_resolve & ~br_mispredict → RUN.
    - br_resolve & br_mispredict → FLUSH, loading flush_cnt = FLUSH_CYCLES.
    - br_resolve outside BR_WAIT is ignored.
  - FLUSH: kill_fc/kill_dc/kill_dp asserted. flush_cnt decrements each cycle; the state leaves to RUN on the edge where flush_cnt==1.
- Stalls, combinational:
  - stall_dp = dp_valid & ~dp_issue.
  - stall_dc = stall_dp.
  - stall_fc = stall_dp | ~fetch_ready.
  - stall_ex = 0; stall_cp = 0.
  - In FLUSH all stalls are 0, so the kills drain the front end.
- Kills: registered. kills[4:2] = 3'b111 exactly while state==FLUSH; kills[1:0] are always 0.
- Scoreboard and ls_cnt are unaffected by a flush; older instructions still complete normally.

## Timing
- Reset: state RUN, scoreboard 0, ls_cnt 0, flush_cnt 0, kills 0. dp_issue and stalls are then functions of the inputs only.
- Issue decision: 0-cycle, same cycle as the inputs. A scoreboard bit is visible from the next cycle.
- Completion unblocks a dependent instruction 1 cycle after cp_we.
- A load/store issued in cycle t blocks the next load/store until cycle t+LS_LATENCY+1. Integer instructions are unaffected.
- Mispredict resolved in cycle t: kills high in cycles t+1 .. t+FLUSH_CYCLES, low in t+FLUSH_CYCLES+1. Dispatch can issue again from t+FLUSH_CYCLES+1.
- Reset asserted mid-FLUSH or mid-BR_WAIT: all state returns to reset values at that edge, and kills are 0 in the following cycle.

## Test plan
- RAW: issue rd=5 (integer), then next cycle rs1=5 → stall_dp=1, stall_fc=1. Apply cp_we with cp_rd=5 → dependent issues exactly 1 cycle later; scoreboard[5] goes 1→0.
- x0/WAW: issue rd=0 → scoreboard stays 0. Issue rd=7, then rd=7 again → second stalls until cp_rd=7 completes.
- Load/store spacing, LS_LATENCY=2: LS issue at t, second LS presented at t+1 → issues at t+3. An integer instruction at t+1 issues immediately.
- Correct branch: issue branch at t → dispatch stalls; br_resolve=1, br_mispredict=0 at t+3 → issue resumes at t+4; kills stay 0.
- Mispredict, FLUSH_CYCLES=2: resolve at t → kills=5'b11100 in t+1 and t+2, 0 at t+3; stalls=0 during the flush. A branch_resolve pulse while in RUN has no effect.
- Reset in FLUSH: reset at t+1 → kills=0 at t+2, scoreboard=0, state RUN, and an instruction presented at t+2 issues.
